// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the regfile port arbiter.
package rf_arb_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    HOLD,
    CAPTURE,
    ACK
  } arb_state_e;

  function automatic logic state_holds_proc(arb_state_e s);
    return (s == DRAIN) || (s == HOLD) || (s == CAPTURE);
  endfunction
endpackage

// File: rtl/rf_arb_fifo.sv
// Debug write queue: synchronous {reg,data} FIFO; a push while full is dropped
// even if a pop happens in the same cycle.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [REG_W-1:0]         push_reg,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [REG_W-1:0]         head_reg,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [REG_W-1:0]   reg_mem_q  [DEPTH];
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic               push_ok;
  logic               pop_ok;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count     = wr_ptr_q - rd_ptr_q;
    push_ok   = push && !full;
    pop_ok    = pop && !empty;
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head_reg  = reg_mem_q[rd_ptr_q[AW-1:0]];
    head_data = data_mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      reg_mem_q[wr_ptr_q[AW-1:0]]  <= push_reg;
      data_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end
endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the regfile between the processor and the debug requester.
// state   | meaning
// IDLE    | accept debug writes into the queue, decode debug reads
// DRAIN   | processor held, queue emptying ahead of a debug read
// HOLD    | processor held, port A driven with dbg_reg
// CAPTURE | processor held, port A data latched into dbg_rdata
// ACK     | one-cycle completion pulse, processor released
module regfile_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_we,
  input  logic [REG_W-1:0]  proc_wreg,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic [REG_W-1:0]  proc_rregA,
  input  logic [REG_W-1:0]  proc_rregB,
  output logic              proc_hold,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [REG_W-1:0]  dbg_reg,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_wreg,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [REG_W-1:0]  rf_rregA,
  output logic [REG_W-1:0]  rf_rregB,
  input  logic [DATA_W-1:0] rf_rdataA
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic              proc_hold_q, proc_hold_d;
  logic              hold_prev_q, hold_prev_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              starve_q, starve_d;

  logic              proc_we_eff;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_will_empty;
  logic [REG_W-1:0]  head_reg;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count;

  rf_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_reg  (dbg_reg),
    .push_data (dbg_wdata),
    .pop       (fifo_pop),
    .head_reg  (head_reg),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The processor already issued its write in the first held cycle; later held cycles are stale.
  always_comb begin
    proc_we_eff     = proc_we && !(proc_hold_q && hold_prev_q);
    fifo_push       = (state_q == IDLE) && dbg_req && dbg_wr && !fifo_full;
    fifo_pop        = !proc_we_eff && !fifo_empty;
    fifo_will_empty = fifo_empty ? !fifo_push
                                 : (fifo_pop && !fifo_push && (fifo_count == CNT_W'(1)));
    rf_we    = 1'b0;
    rf_wreg  = '0;
    rf_wdata = '0;
    if (proc_we_eff) begin
      rf_we    = (proc_wreg != REG_ZERO);
      rf_wreg  = proc_wreg;
      rf_wdata = proc_wdata;
    end else if (!fifo_empty) begin
      rf_we    = (head_reg != REG_ZERO);
      rf_wreg  = head_reg;
      rf_wdata = head_data;
    end
    rf_rregA = ((state_q == HOLD) || (state_q == CAPTURE)) ? dbg_reg : proc_rregA;
    rf_rregB = proc_rregB;
  end

  always_comb begin
    state_d     = state_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          if (dbg_wr) begin
            if (!fifo_full) state_d = ACK;
          end else begin
            state_d = fifo_empty ? HOLD : DRAIN;
          end
        end
      end
      DRAIN:   if (fifo_empty) state_d = HOLD;
      HOLD:    state_d = CAPTURE;
      CAPTURE: begin
        dbg_rdata_d = rf_rdataA;
        state_d     = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Once starving, the count stays saturated until the queue is fully drained.
    starve_cnt_d = starve_cnt_q;
    starve_d     = starve_q;
    if (starve_q) begin
      if (fifo_will_empty) begin
        starve_d     = 1'b0;
        starve_cnt_d = '0;
      end
    end else begin
      if (fifo_pop) begin
        starve_cnt_d = '0;
      end else if (!fifo_empty && proc_we_eff && (starve_cnt_q != SC_W'(STARVE_LIMIT))) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
      if (starve_cnt_d == SC_W'(STARVE_LIMIT)) starve_d = 1'b1;
    end

    proc_hold_d = starve_d || state_holds_proc(state_d);
    hold_prev_d = proc_hold_q;
    dbg_ack_d   = (state_d == ACK);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      proc_hold_q  <= 1'b0;
      hold_prev_q  <= 1'b0;
      dbg_ack_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      proc_hold_q  <= proc_hold_d;
      hold_prev_q  <= hold_prev_d;
      dbg_ack_q    <= dbg_ack_d;
      dbg_rdata_q  <= dbg_rdata_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign proc_hold = proc_hold_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
endmodule
